// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: draws LFSR cells, checks them against snake occupancy,
// and commits the accepted cell as pixel coordinates only at a frame boundary.
module apple_spawn_ctrl #(
  parameter int BIT       = 10,
  parameter int SIZE      = 20,
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int CELL_BITS = 5,
  parameter int MAX_TRIES = 15,
  parameter int INIT_CX   = 24,
  parameter int INIT_CY   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_restart,
  input  logic                 eaten,
  input  logic                 frame_start,
  output logic                 occ_req,
  output logic [CELL_BITS-1:0] occ_cx,
  output logic [CELL_BITS-1:0] occ_cy,
  input  logic                 occ_ack,
  input  logic                 occ_hit,
  output logic [BIT-1:0]       apple_x_start,
  output logic [BIT-1:0]       apple_y_start,
  output logic                 apple_valid,
  output logic                 busy,
  output logic                 spawn_fail
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [CELL_BITS:0] GW     = (CELL_BITS+1)'(GRID_W);
  localparam logic [CELL_BITS:0] GH     = (CELL_BITS+1)'(GRID_H);
  localparam logic [BIT-1:0]     INIT_X = BIT'(INIT_CX * SIZE);
  localparam logic [BIT-1:0]     INIT_Y = BIT'(INIT_CY * SIZE);
  localparam logic [15:0]        SEED   = 16'hACE1;

  typedef enum logic [2:0] {IDLE, GEN, QUERY, BACKOFF, PENDING} state_t;
  typedef struct packed {
    logic [CELL_BITS-1:0] cx;
    logic [CELL_BITS-1:0] cy;
  } cell_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [TW-1:0] tries;
  cell_t         cand, cand_nxt;

  // Grid dims exceed half the index range, so one conditional subtract folds any index in.
  function automatic logic [CELL_BITS-1:0] wrap(input logic [CELL_BITS-1:0] r,
                                                input logic [CELL_BITS:0]   lim);
    logic [CELL_BITS:0] r1;
    r1 = {1'b0, r};
    return (r1 >= lim) ? CELL_BITS'(r1 - lim) : r;
  endfunction

  function automatic logic [BIT-1:0] px(input logic [CELL_BITS-1:0] c);
    return BIT'(int'(c) * SIZE);
  endfunction

  always_comb begin
    cand_nxt    = '0;
    cand_nxt.cx = wrap(lfsr[CELL_BITS-1:0], GW);
    cand_nxt.cy = wrap(lfsr[CELL_BITS+7:8], GH);
  end

  assign occ_cx = cand.cx;
  assign occ_cy = cand.cy;
  assign busy   = (state != IDLE);

  // Free-running; restart deliberately keeps the sequence going so respawns differ.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cand          <= '0;
      tries         <= '0;
      occ_req       <= 1'b0;
      spawn_fail    <= 1'b0;
      apple_valid   <= 1'b1;
      apple_x_start <= INIT_X;
      apple_y_start <= INIT_Y;
    end else begin
      spawn_fail <= 1'b0;
      if (game_restart) begin
        state         <= IDLE;
        tries         <= '0;
        occ_req       <= 1'b0;
        apple_valid   <= 1'b1;
        apple_x_start <= INIT_X;
        apple_y_start <= INIT_Y;
      end else begin
        case (state)
          IDLE: if (eaten) begin
            apple_valid <= 1'b0;
            tries       <= '0;
            state       <= GEN;
          end
          GEN: begin
            cand    <= cand_nxt;
            tries   <= tries + TW'(1);
            occ_req <= 1'b1;
            state   <= QUERY;
          end
          QUERY: if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit)                      state <= PENDING;
            else if (tries == TW'(MAX_TRIES)) begin
              spawn_fail <= 1'b1;
              state      <= BACKOFF;
            end else                           state <= GEN;
          end
          BACKOFF: if (frame_start) begin
            tries <= '0;
            state <= GEN;
          end
          // Commit only on vblank so the drawer never shows a half-moved apple.
          PENDING: if (frame_start) begin
            apple_x_start <= px(cand.cx);
            apple_y_start <= px(cand.cy);
            apple_valid   <= 1'b1;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Scoreboard bench for apple_spawn_ctrl: stimulus queues expected queries/commits,
// an occupancy responder and a commit monitor pop and compare.
module tb_apple_spawn_ctrl;
  localparam int GW = 32, GH = 24, SZ = 20;

  typedef struct {int cx; int cy;} cell_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       game_restart = 1'b0, eaten = 1'b0, frame_start = 1'b0;
  logic       occ_req, occ_ack = 1'b0, occ_hit = 1'b0;
  logic [4:0] occ_cx, occ_cy;
  logic [9:0] apple_x_start, apple_y_start;
  logic       apple_valid, busy, spawn_fail;

  apple_spawn_ctrl dut (
    .clk(clk), .rst_n(rst_n), .game_restart(game_restart), .eaten(eaten),
    .frame_start(frame_start), .occ_req(occ_req), .occ_cx(occ_cx), .occ_cy(occ_cy),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .apple_x_start(apple_x_start),
    .apple_y_start(apple_y_start), .apple_valid(apple_valid), .busy(busy),
    .spawn_fail(spawn_fail)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0, n_bad = 0;
  cell_t q_query[$];
  cell_t q_commit[$];
  bit    hit_q[$];
  int    ack_delay = 0;
  int    stray_req = 0, stray_done = 0;
  int    fail_exp = 0, fail_seen = 0;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l, input int n);
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic cell_t lcell(input logic [15:0] l);
    cell_t c;
    int rx, ry;
    rx = int'(l[4:0]);
    ry = int'(l[12:8]);
    c.cx = (rx >= GW) ? rx - GW : rx;
    c.cy = (ry >= GH) ? ry - GH : ry;
    return c;
  endfunction

  // Reference LFSR: value held here during a cycle equals the DUT's during that cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lstep(m_lfsr, 1);

  // Occupancy responder + query checker.
  initial begin
    int wcnt = 0, pcx = 0, pcy = 0;
    bit pend = 0;
    cell_t e;
    forever begin
      @(negedge clk);
      if (occ_req) begin
        if (pend) begin
          check("occ_cx_stable", occ_cx, pcx);
          check("occ_cy_stable", occ_cy, pcy);
        end
        if (wcnt >= ack_delay) begin
          occ_ack = 1'b1;
          occ_hit = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
          wcnt = 0;
          pend = 0;
          check("query_expected", int'(q_query.size() > 0), 1);
          if (q_query.size() > 0) begin
            e = q_query.pop_front();
            check("query_cx", occ_cx, e.cx);
            check("query_cy", occ_cy, e.cy);
            check("query_cy_range", int'(occ_cy < GH), 1);
          end
        end else begin
          occ_ack = 1'b0;
          wcnt++;
          pend = 1;
          pcx = occ_cx;
          pcy = occ_cy;
        end
      end else if (stray_req != stray_done) begin
        occ_ack = 1'b1;
        occ_hit = 1'b1;
        stray_done++;
        wcnt = 0;
        pend = 0;
      end else begin
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        wcnt = 0;
        pend = 0;
      end
    end
  end

  // Commit / spawn_fail monitor.
  initial begin
    logic prev_valid = 1'b1;
    cell_t e;
    forever begin
      @(negedge clk);
      if (apple_valid === 1'b1 && prev_valid !== 1'b1) begin
        check("commit_expected", int'(q_commit.size() > 0), 1);
        if (q_commit.size() > 0) begin
          e = q_commit.pop_front();
          check("commit_x", apple_x_start, e.cx);
          check("commit_y", apple_y_start, e.cy);
        end
      end
      if (spawn_fail === 1'b1) begin
        check("spawn_fail_expected", int'(fail_seen < fail_exp), 1);
        fail_seen++;
      end
      prev_valid = apple_valid;
    end
  end

  task automatic push_commit(input int x, input int y);
    cell_t c;
    c.cx = x;
    c.cy = y;
    q_commit.push_back(c);
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  // Issue eaten; queue the model's cells for every GEN the retry pattern implies.
  task automatic do_spawn(input int d, input int nhits, input bit with_fs, input bit commit);
    logic [15:0] v;
    cell_t c;
    int nq;
    @(negedge clk);
    ack_delay = d;
    for (int k = 0; k < nhits; k++) hit_q.push_back(1'b1);
    eaten = 1'b1;
    frame_start = with_fs;
    v = m_lfsr;
    nq = (nhits >= 15) ? 15 : nhits + 1;
    for (int k = 0; k < nq; k++) begin
      c = lcell(lstep(v, 1 + k * (d + 2)));
      q_query.push_back(c);
    end
    if (commit) push_commit(c.cx * SZ, c.cy * SZ);
    @(negedge clk);
    eaten = 1'b0;
    frame_start = 1'b0;
    check("valid_low_after_eaten", apple_valid, 0);
    check("busy_after_eaten", busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    cell_t c;
    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_x", apple_x_start, 480);
    check("rst_y", apple_y_start, 240);
    check("rst_valid", apple_valid, 1);
    check("rst_occ_req", occ_req, 0);
    check("rst_busy", busy, 0);
    check("rst_fail", spawn_fail, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: async reset while in QUERY
    do_spawn(20, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_in_query", occ_req, 1);
    push_commit(480, 240);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q_query.delete();
    #1;
    check("t1_x", apple_x_start, 480);
    check("t1_y", apple_y_start, 240);
    check("t1_valid", apple_valid, 1);
    check("t1_occ_req", occ_req, 0);
    check("t1_busy", busy, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Test 2: hand vector; LFSR 0x59C3 at eaten -> GEN sees 0xB387 -> cell (7,19)
    @(negedge clk);
    ack_delay = 0;
    eaten = 1'b1;
    c.cx = 7; c.cy = 19;
    q_query.push_back(c);
    push_commit(140, 380);
    @(negedge clk); eaten = 1'b0;
    check("t2_valid_low", apple_valid, 0);
    @(negedge clk); frame_start = 1'b1;     // accepted in same cycle as frame_start
    @(negedge clk); frame_start = 1'b0;
    stray_req++;                            // ack while PENDING must be ignored
    repeat (2) @(negedge clk);
    check("t2_no_same_cycle_commit", apple_valid, 0);
    check("t2_busy_pending", busy, 1);
    pulse_fs();
    @(negedge clk);
    check("t2_idle", busy, 0);
    check("t2_x_hold", apple_x_start, 140);

    // Test 3: two collisions then free; eaten coincident with frame_start in IDLE
    do_spawn(0, 2, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    pulse_fs();
    repeat (2) @(negedge clk);
    check("t3_idle", busy, 0);

    // Test 4: ack delayed 5 cycles; eaten while busy ignored
    do_spawn(5, 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    repeat (8) @(negedge clk);
    pulse_fs();
    repeat (2) @(negedge clk);
    check("t4_idle", busy, 0);

    // Test 5: exhaustion, backoff, resume on frame_start
    fail_exp = 1;
    do_spawn(0, 15, 1'b0, 1'b0);
    repeat (35) @(negedge clk);
    eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_backoff", busy, 1);
    check("t5_valid_backoff", apple_valid, 0);
    check("t5_no_req_backoff", occ_req, 0);
    check("t5_fail_seen", fail_seen, 1);
    @(negedge clk);
    frame_start = 1'b1;
    v = m_lfsr;
    c = lcell(lstep(v, 1));
    q_query.push_back(c);
    push_commit(c.cx * SZ, c.cy * SZ);
    @(negedge clk); frame_start = 1'b0;
    repeat (5) @(negedge clk);
    pulse_fs();
    repeat (2) @(negedge clk);
    check("t5_idle", busy, 0);

    // Test 6: restart coincident with frame_start while PENDING
    do_spawn(0, 0, 1'b0, 1'b0);
    push_commit(480, 240);
    repeat (2) @(negedge clk);
    check("t6_pending", busy, 1);
    game_restart = 1'b1;
    frame_start  = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    frame_start  = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_occ_req", occ_req, 0);
    check("t6_x", apple_x_start, 480);
    check("t6_y", apple_y_start, 240);
    pulse_fs();                             // frame_start alone in IDLE does nothing
    @(negedge clk);
    check("t6_fs_idle", busy, 0);

    repeat (3) @(negedge clk);
    check("end_query_q", q_query.size(), 0);
    check("end_commit_q", q_commit.size(), 0);
    check("end_fail_count", fail_seen, fail_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apple_spawn_ctrl.md
Name: apple_spawn_ctrl

Overview:
- Sequences apple placement for the snake game.
- On an "eaten" event it draws pseudo-random grid cells from a free-running LFSR. It checks each candidate against the snake-occupancy unit over a request/acknowledge handshake, retrying on collision.
- It commits the accepted cell as pixel coordinates to the apple drawer, only at a frame boundary, so the apple never tears mid-frame.
- It sits between game logic, snake body storage and the apple draw unit.

Parameters:
BIT, 10, pixel coordinate width
SIZE, 20, apple/cell size in px
GRID_W, 32, grid columns (640/SIZE)
GRID_H, 24, grid rows (480/SIZE)
CELL_BITS, 5, cell index width; GRID_W and GRID_H must be > 2^(CELL_BITS-1) and <= 2^CELL_BITS
MAX_TRIES, 15, candidates tried per frame before backoff
INIT_CX, 24, reset/restart apple column
INIT_CY, 12, reset/restart apple row

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
game_restart  in  1  synchronous one-cycle pulse: abort and return to initial apple
eaten  in  1  one-cycle pulse: snake head consumed apple
frame_start  in  1  one-cycle pulse at start of vertical blanking
occ_req  out  1  occupancy query valid
occ_cx  out  CELL_BITS  queried column
occ_cy  out  CELL_BITS  queried row
occ_ack  in  1  query answered this cycle
occ_hit  in  1  cell occupied by snake (valid with occ_ack)
apple_x_start  out  BIT  apple left edge px (cx*SIZE)
apple_y_start  out  BIT  apple top edge px (cy*SIZE)
apple_valid  out  1  apple shown/eatable
busy  out  1  state != IDLE
spawn_fail  out  1  one-cycle pulse when MAX_TRIES exhausted

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; apple cell (INIT_CX, INIT_CY), so apple_x_start = INIT_CX*SIZE (480) and apple_y_start = INIT_CY*SIZE (240).
  - apple_valid=1, occ_req=0, spawn_fail=0, tries=0, LFSR=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, advances every cycle regardless of state.
  - next = {l[14:0], l[15]^l[13]^l[12]^l[10]}; never reaches 0.
- Candidate (sampled in GEN):
  - rx = l[CELL_BITS-1:0], ry = l[CELL_BITS+7:8].
  - cx = rx>=GRID_W ? rx-GRID_W : rx; cy likewise with GRID_H (single conditional subtract).
- Pixel outputs are registered products cell*SIZE, truncated to BIT. They change only at commit or restart.
- States:
  - IDLE: on eaten -> apple_valid<=0, tries<=0, go GEN. frame_start alone is ignored.
  - GEN: latch cx/cy, tries<=tries+1, go QUERY (1 cycle).
  - QUERY:
    - occ_req=1 with occ_cx/occ_cy held stable until occ_ack, which may arrive the same cycle occ_req rises or any later cycle.
    - On ack with hit=0 -> PENDING.
    - On ack with hit=1 and tries<MAX_TRIES -> GEN.
    - On ack with hit=1 and tries==MAX_TRIES -> spawn_fail pulse, go BACKOFF.
    - occ_req drops the cycle after ack.
  - BACKOFF: wait frame_start -> tries<=0, go GEN.
  - PENDING: wait frame_start; in that cycle register cell, pixel outputs and apple_valid<=1; go IDLE. New values are visible the next cycle.
- Boundaries:
  - eaten while busy: ignored (apple already hidden).
  - eaten and frame_start in the same IDLE cycle: eaten taken.
  - Accepted candidate in the same cycle as frame_start: PENDING waits for the next frame_start (no same-cycle commit).
  - game_restart has priority over all inputs in any state: next cycle IDLE, occ_req=0, initial cell, apple_valid=1, tries=0. The LFSR is not reseeded.
  - occ_ack outside QUERY: ignored.
- Worst-case latency from eaten to visible apple: 2 cycles per try plus ack delays, then up to one frame.

Test Plan:
1. Reset mid-operation (in QUERY) -> outputs immediately 480/240, apple_valid=1, occ_req=0, busy=0; LFSR restarts 0xACE1, 0x59C3, ...
2. eaten, occ_ack same cycle as occ_req with hit=0:
   - apple_valid=0 the cycle after eaten.
   - Exactly one query, whose cell matches the LFSR model state at GEN.
   - At next frame_start, outputs = cx*20, cy*20 and apple_valid=1 the following cycle.
3. Collision retries: ack hit=1 twice then hit=0 -> three distinct queries, each cx<32 and cy<24; commit uses the third cell.
4. Delayed handshake: occ_ack held off 5 cycles -> occ_req, occ_cx and occ_cy stable for all 6 cycles; no second GEN.
5. Exhaustion: hit=1 for 15 acks -> spawn_fail pulses once and no query until frame_start; then tries restarts and a query resumes. eaten during BACKOFF has no effect.
6. game_restart asserted while PENDING, coincident with frame_start -> no commit; outputs 480/240, apple_valid=1, state IDLE.
